lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store controller; produces load data for the writeback select mux (load input, sel=2'b01).
//  Accepts one core load/store per request and drives a word-wide data memory.
//  The memory uses a variable-latency req/ack handshake.
//  Does byte-lane alignment, sign/zero extension, misalign/illegal detection, timeout, and core stall.
// PARAMETERS
//  TIMEOUT_CYC  256  max BUSY cycles waiting for mem_i_ack before timeout fault (>=2)
// PORTS
//  i_clk              in   1   clock; all state on rising edge
//  i_reset            in   1   synchronous, active-high reset
//  lsu_i_req          in   1   core load/store request; held by core while lsu_o_stall=1
//  lsu_i_we           in   1   1=store, 0=load
//  lsu_i_funct3       in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  lsu_i_addr         in   32  byte address
//  lsu_i_wdata        in   32  store data (rs2)
//  lsu_o_stall        out  1   combinational; core must hold pipeline/request
//  lsu_o_rdata        out  32  formatted load data -> writeback mux
//  lsu_o_valid        out  1   1-cycle pulse: access completed without fault
//  lsu_o_fault        out  1   1-cycle pulse: access aborted
//  lsu_o_fault_cause  out  2   01 misalign, 10 illegal funct3, 11 timeout; 00 when no fault
//  mem_o_req          out  1   memory request, held until ack
//  mem_o_we           out  1   memory write enable
//  mem_o_addr         out  32  word address, {addr[31:2],2'b00}
//  mem_o_wdata        out  32  lane-replicated store data
//  mem_o_bmask        out  4   byte-lane enables (loads: lanes read)
//  mem_i_ack          in   1   memory completion; rdata valid same cycle for loads
//  mem_i_rdata        in   32  memory read word
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, every registered output 0 (rdata, valid, fault, cause, mem_o_*).
//  - Reset mid-access drops mem_o_req on the next edge; an ack arriving outside BUSY is ignored.
//  - FSM IDLE/BUSY/DONE:
//    - IDLE + req, legal and aligned: latch we/funct3/addr/wdata -> BUSY.
//    - IDLE + req, illegal or misaligned: -> DONE with fault; no memory access.
//    - BUSY: mem_o_req=1.
//      - ack -> DONE with valid.
//      - Else counter++; if counter==TIMEOUT_CYC-1 -> DONE with fault cause 11 and rdata=0.
//      - Ack on the final cycle wins over timeout.
//    - DONE: exactly 1 cycle; outputs valid/fault pulse; unconditional -> IDLE; lsu_i_req ignored.
//  - Stall: lsu_o_stall = (IDLE & lsu_i_req) | BUSY. Low in DONE, so the core advances on the DONE edge.
//  - Latency: request seen at cycle 0; BUSY from cycle 1; ack at cycle 1 -> DONE/valid at cycle 2.
//    Minimum 3 cycles between back-to-back requests.
//  - Misalign: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Byte access never misaligned.
//  - Illegal: loads with funct3 011/110/111; stores with funct3[2]=1 or 011. Illegal takes priority over misalign.
//  - Stores, k=addr[1:0]:
//    - SB: bmask=1<<k, wdata={4{b}}.
//    - SH: bmask=k[1]?1100:0011, wdata={2{h}}.
//    - SW: 1111.
//    - Store completion: valid pulse, rdata=0.
//  - Loads: lane from mem_i_rdata captured at ack.
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
//    - lsu_o_rdata holds the value until the next completion.
//  - Counter width $clog2(TIMEOUT_CYC); cleared on entry to BUSY; no wrap possible.
// STRUCTURE
//  - lsu_pkg:
//    - state enum {IDLE,BUSY,DONE}.
//    - funct3 localparams F3_B/H/W/BU/HU.
//    - fault cause localparams.
//  - Sub-module lsu_lane_fmt (combinational):
//    - store wdata/bmask generation.
//    - load lane extract and extend.
//    - alignment/illegal checks.
//  - lsu_ctrl holds the FSM, latches, counter and output registers.
// TESTING
//  - LW addr 0x100, ack 1st BUSY cycle, rdata 0xDEADBEEF -> stall cycles 0-1, valid+rdata=0xDEADBEEF at cycle 2.
//  - LB addr 0x103, rdata 0x80FF0000 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
//  - SB addr 0x201 wdata 0x12345678 -> mem_o_addr 0x200, bmask 0010, wdata 0x78787878.
//    Same for SH 0x202 -> bmask 1100, wdata 0x56785678.
//  - LW addr 0x102 -> no mem_o_req, DONE fault cause 01 at cycle 1.
//    Store funct3 100 -> fault cause 10.
//  - Timeout: TIMEOUT_CYC=4, no ack -> 4 BUSY cycles, fault cause 11, rdata 0.
//    Ack in 4th BUSY cycle -> valid, no fault.
//  - i_reset during BUSY with ack 1 cycle later -> IDLE, outputs 0, late ack ignored, next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store controller: FSM states,
// RV32I load/store funct3 codes, fault causes and the byte-lane mask helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // size is funct3[1:0]: 00 byte, 01 half, otherwise word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] k);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << k;
      2'b01:   m = k[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational lane formatter: legality/alignment checks and store lane
// replication for the incoming request, lane extract/extend for returning loads.
module lsu_lane_fmt (
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic        req_illegal,
  output logic        req_misalign,
  output logic [3:0]  req_bmask,
  output logic [31:0] req_wdata_fmt,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);
  import lsu_pkg::*;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req_illegal   = 1'b0;
    req_misalign  = 1'b0;
    req_bmask     = lane_mask(req_funct3[1:0], req_addr_lo);
    req_wdata_fmt = 32'd0;

    if (req_we) begin
      req_illegal = req_funct3[2] | (req_funct3 == 3'b011);
    end else begin
      req_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end

    case (req_funct3[1:0])
      2'b01:   req_misalign = req_addr_lo[0];
      2'b10:   req_misalign = (req_addr_lo != 2'b00);
      default: req_misalign = 1'b0;
    endcase

    // Loads leave the write bus quiet; stores replicate the datum across lanes.
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00:   req_wdata_fmt = {4{req_wdata[7:0]}};
        2'b01:   req_wdata_fmt = {2{req_wdata[15:0]}};
        default: req_wdata_fmt = req_wdata;
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'd0;
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access per request, memory req held until ack or timeout.
// Completion pulse one cycle after ack; core stalled while a request is pending or BUSY.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        lsu_i_req,
  input  logic        lsu_i_we,
  input  logic [2:0]  lsu_i_funct3,
  input  logic [31:0] lsu_i_addr,
  input  logic [31:0] lsu_i_wdata,
  output logic        lsu_o_stall,
  output logic [31:0] lsu_o_rdata,
  output logic        lsu_o_valid,
  output logic        lsu_o_fault,
  output logic [1:0]  lsu_o_fault_cause,
  output logic        mem_o_req,
  output logic        mem_o_we,
  output logic [31:0] mem_o_addr,
  output logic [31:0] mem_o_wdata,
  output logic [3:0]  mem_o_bmask,
  input  logic        mem_i_ack,
  input  logic [31:0] mem_i_rdata
);
  import lsu_pkg::*;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [1:0]       cause_q, cause_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_bmask_q, mem_bmask_d;

  logic        req_illegal;
  logic        req_misalign;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata_fmt;
  logic [31:0] ld_data;

  lsu_lane_fmt u_fmt (
    .req_we        (lsu_i_we),
    .req_funct3    (lsu_i_funct3),
    .req_addr_lo   (lsu_i_addr[1:0]),
    .req_wdata     (lsu_i_wdata),
    .req_illegal   (req_illegal),
    .req_misalign  (req_misalign),
    .req_bmask     (req_bmask),
    .req_wdata_fmt (req_wdata_fmt),
    .ld_funct3     (funct3_q),
    .ld_addr_lo    (addr_lo_q),
    .ld_word       (mem_i_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    rdata_d     = rdata_q;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    cause_d     = CAUSE_NONE;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;

    case (state_q)
      IDLE: begin
        if (lsu_i_req) begin
          if (req_illegal || req_misalign) begin
            // Rejected before touching memory; illegal outranks misalign.
            state_d = DONE;
            fault_d = 1'b1;
            cause_d = req_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            rdata_d = 32'd0;
          end else begin
            state_d     = BUSY;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            we_d        = lsu_i_we;
            funct3_d    = lsu_i_funct3;
            addr_lo_d   = lsu_i_addr[1:0];
            mem_addr_d  = {lsu_i_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata_fmt;
            mem_bmask_d = req_bmask;
          end
        end
      end

      BUSY: begin
        if (mem_i_ack) begin
          state_d = DONE;
          valid_d = 1'b1;
          rdata_d = we_q ? 32'd0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          rdata_d = 32'd0;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      rdata_q     <= 32'd0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= CAUSE_NONE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_bmask_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
    end
  end

  // DONE deliberately drops stall so the core advances on the completion edge.
  assign lsu_o_stall       = ((state_q == IDLE) && lsu_i_req) || (state_q == BUSY);
  assign lsu_o_rdata       = rdata_q;
  assign lsu_o_valid       = valid_q;
  assign lsu_o_fault       = fault_q;
  assign lsu_o_fault_cause = cause_q;
  assign mem_o_req         = mem_req_q;
  assign mem_o_we          = we_q;
  assign mem_o_addr        = mem_addr_q;
  assign mem_o_wdata       = mem_wdata_q;
  assign mem_o_bmask       = mem_bmask_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed plus randomized bench for lsu_ctrl against an arithmetic reference
// model of the load/store rules, with a short timeout budget.
module tb_lsu_ctrl;

  localparam int TCYC = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        lsu_i_req;
  logic        lsu_i_we;
  logic [2:0]  lsu_i_funct3;
  logic [31:0] lsu_i_addr;
  logic [31:0] lsu_i_wdata;
  logic        lsu_o_stall;
  logic [31:0] lsu_o_rdata;
  logic        lsu_o_valid;
  logic        lsu_o_fault;
  logic [1:0]  lsu_o_fault_cause;
  logic        mem_o_req;
  logic        mem_o_we;
  logic [31:0] mem_o_addr;
  logic [31:0] mem_o_wdata;
  logic [3:0]  mem_o_bmask;
  logic        mem_i_ack;
  logic [31:0] mem_i_rdata;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  lsu_ctrl #(.TIMEOUT_CYC(TCYC)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .lsu_i_req         (lsu_i_req),
    .lsu_i_we          (lsu_i_we),
    .lsu_i_funct3      (lsu_i_funct3),
    .lsu_i_addr        (lsu_i_addr),
    .lsu_i_wdata       (lsu_i_wdata),
    .lsu_o_stall       (lsu_o_stall),
    .lsu_o_rdata       (lsu_o_rdata),
    .lsu_o_valid       (lsu_o_valid),
    .lsu_o_fault       (lsu_o_fault),
    .lsu_o_fault_cause (lsu_o_fault_cause),
    .mem_o_req         (mem_o_req),
    .mem_o_we          (mem_o_we),
    .mem_o_addr        (mem_o_addr),
    .mem_o_wdata       (mem_o_wdata),
    .mem_o_bmask       (mem_o_bmask),
    .mem_i_ack         (mem_i_ack),
    .mem_i_rdata       (mem_i_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_illegal(input bit we, input logic [2:0] f3);
    if (we) return !(f3 inside {3'd0, 3'd1, 3'd2});
    return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic bit ref_misalign(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_bmask(input logic [2:0] f3, input logic [31:0] addr);
    int s   = acc_size(f3);
    int off = int'(addr[1:0]);
    off = off - (off % s);
    return 4'(((1 << s) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int s = acc_size(f3);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int s = acc_size(f3);
    logic [31:0] v;
    logic [31:0] lim;
    v = word >> (8 * int'(addr[1:0]));
    if (s < 4) begin
      lim = 32'd1 << (8 * s);
      v   = v & (lim - 32'd1);
      if (!f3[2] && v >= (lim >> 1)) v = v | ~(lim - 32'd1);
    end
    return v;
  endfunction

  // One full request: ack_cyc is the BUSY cycle (1-based) carrying ack; 0 = never.
  task automatic access(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input int ack_cyc);
    bit          ill = ref_illegal(we, f3);
    bit          mis = !ill && ref_misalign(f3, addr);
    int          busy = 0;
    bit          fin  = 0;
    bit          acked;
    logic [31:0] exp_rd;

    @(posedge i_clk); #1;
    lsu_i_req = 1'b1; lsu_i_we = we; lsu_i_funct3 = f3;
    lsu_i_addr = addr; lsu_i_wdata = wd;
    @(negedge i_clk);
    chk({tag, "_stall0"}, 32'(lsu_o_stall), 32'd1);
    chk({tag, "_memreq0"}, 32'(mem_o_req), 32'd0);

    if (ill || mis) begin
      @(posedge i_clk); #1;
      lsu_i_req = 1'b0;
      @(negedge i_clk);
      chk({tag, "_fault"}, 32'(lsu_o_fault), 32'd1);
      chk({tag, "_valid"}, 32'(lsu_o_valid), 32'd0);
      chk({tag, "_cause"}, 32'(lsu_o_fault_cause), ill ? 32'd2 : 32'd1);
      chk({tag, "_nomem"}, 32'(mem_o_req), 32'd0);
      chk({tag, "_stall_done"}, 32'(lsu_o_stall), 32'd0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk({tag, "_fault_pulse"}, 32'(lsu_o_fault), 32'd0);
      chk({tag, "_cause_clr"}, 32'(lsu_o_fault_cause), 32'd0);
      return;
    end

    while (!fin) begin
      @(posedge i_clk); #1;
      busy++;
      mem_i_ack   = (busy == ack_cyc);
      mem_i_rdata = mem_i_ack ? word : $urandom;
      @(negedge i_clk);
      chk({tag, "_memreq"}, 32'(mem_o_req), 32'd1);
      chk({tag, "_stall_busy"}, 32'(lsu_o_stall), 32'd1);
      if (busy == 1) begin
        chk({tag, "_addr"}, mem_o_addr, {addr[31:2], 2'b00});
        chk({tag, "_bmask"}, 32'(mem_o_bmask), 32'(ref_bmask(f3, addr)));
        chk({tag, "_we"}, 32'(mem_o_we), 32'(we));
        if (we) chk({tag, "_wdata"}, mem_o_wdata, ref_wdata(f3, wd));
      end
      if (mem_i_ack || busy >= TCYC) fin = 1;
    end

    acked  = (busy == ack_cyc);
    exp_rd = (acked && !we) ? ref_load(f3, addr, word) : 32'd0;

    @(posedge i_clk); #1;
    mem_i_ack = 1'b0; lsu_i_req = 1'b0;
    @(negedge i_clk);
    chk({tag, "_done_valid"}, 32'(lsu_o_valid), 32'(acked));
    chk({tag, "_done_fault"}, 32'(lsu_o_fault), 32'(!acked));
    chk({tag, "_done_cause"}, 32'(lsu_o_fault_cause), acked ? 32'd0 : 32'd3);
    chk({tag, "_rdata"}, lsu_o_rdata, exp_rd);
    chk({tag, "_stall_done"}, 32'(lsu_o_stall), 32'd0);
    chk({tag, "_memreq_done"}, 32'(mem_o_req), 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk({tag, "_pulse"}, 32'(lsu_o_valid | lsu_o_fault), 32'd0);
    chk({tag, "_rdata_hold"}, lsu_o_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; lsu_i_req = 1'b0; lsu_i_we = 1'b0; lsu_i_funct3 = 3'd0;
    lsu_i_addr = 32'd0; lsu_i_wdata = 32'd0; mem_i_ack = 1'b0; mem_i_rdata = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_rdata", lsu_o_rdata, 32'd0);
    chk("rst_valid", 32'(lsu_o_valid), 32'd0);
    chk("rst_fault", 32'(lsu_o_fault), 32'd0);
    chk("rst_cause", 32'(lsu_o_fault_cause), 32'd0);
    chk("rst_memreq", 32'(mem_o_req), 32'd0);
    chk("rst_mem_bus", mem_o_addr | mem_o_wdata | 32'(mem_o_bmask) | 32'(mem_o_we), 32'd0);
    chk("rst_stall", 32'(lsu_o_stall), 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    access("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    chk("lw100_const", lsu_o_rdata, 32'hDEADBEEF);
    access("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 2);
    chk("lb103_const", lsu_o_rdata, 32'hFFFFFF80);
    access("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1);
    chk("lbu103_const", lsu_o_rdata, 32'h00000080);
    access("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 3);
    chk("lhu102_const", lsu_o_rdata, 32'h000080FF);
    access("sb201", 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 1);
    access("sh202", 1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 2);
    access("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
    access("st100", 1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 1);
    access("ill_mis", 1'b0, 3'b111, 32'h101, 32'h0, 32'h0, 1);
    access("tmo", 1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0);
    access("ack_last", 1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, TCYC);

    // Reset while BUSY, then an ack arriving after reset must be ignored.
    @(posedge i_clk); #1;
    lsu_i_req = 1'b1; lsu_i_we = 1'b0; lsu_i_funct3 = 3'b010; lsu_i_addr = 32'h300;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rstb_memreq_busy", 32'(mem_o_req), 32'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b0; lsu_i_req = 1'b0; mem_i_ack = 1'b1; mem_i_rdata = 32'hA5A5A5A5;
    @(negedge i_clk);
    chk("rstb_memreq", 32'(mem_o_req), 32'd0);
    chk("rstb_stall", 32'(lsu_o_stall), 32'd0);
    chk("rstb_out", lsu_o_rdata | 32'(lsu_o_valid) | 32'(lsu_o_fault), 32'd0);
    @(posedge i_clk); #1;
    mem_i_ack = 1'b0;
    @(negedge i_clk);
    chk("rstb_late_ack", 32'(lsu_o_valid | lsu_o_fault | mem_o_req), 32'd0);
    chk("rstb_rdata", lsu_o_rdata, 32'd0);
    access("lw_after_rst", 1'b0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [2:0]  f;
      bit          w;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = f & 3'b101;
      w = 1'($urandom_range(0, 1));
      access("rnd", w, f, a, $urandom, $urandom, int'($urandom_range(0, TCYC + 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
